// File: rtl/cdb_arbiter_param_pkg.sv
// Shared definitions for the CDB arbiter: default geometry, the source request
// record and the starve-counter width helper.
package cdb_arbiter_param_pkg;

  localparam int DEF_N_SRC        = 8;
  localparam int DEF_N_CDB        = 2;
  localparam int DEF_ROB_IDX_W    = 4;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_EX_W         = 8;
  localparam int DEF_STARVE_LIMIT = 7;

  typedef struct packed {
    logic [DEF_ROB_IDX_W-1:0] reorder;
    logic [DEF_DATA_W-1:0]    data;
    logic [DEF_EX_W-1:0]      ex;
  } cdb_src_req_t;

  function automatic int starve_cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/cdb_age_select.sv
// One CDB slot picker: urgent beats non-urgent, then smallest age, then lowest
// index. Purely combinational; the caller masks out earlier slots' picks.
module cdb_age_select #(
  parameter int N_SRC = 8,
  parameter int AGE_W = 4
) (
  input  logic [N_SRC-1:0]            req_i,
  input  logic [N_SRC-1:0][AGE_W-1:0] age_i,
  input  logic [N_SRC-1:0]            urgent_i,
  output logic [N_SRC-1:0]            pick_o
);

  logic             found;
  logic             best_urg;
  logic [AGE_W-1:0] best_age;
  logic [N_SRC-1:0] best_oh;

  // Strict comparisons keep the earlier (lower) index on a full tie.
  always_comb begin
    found    = 1'b0;
    best_urg = 1'b0;
    best_age = '0;
    best_oh  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (req_i[i] && (!found ||
                       (urgent_i[i] && !best_urg) ||
                       ((urgent_i[i] == best_urg) && (age_i[i] < best_age)))) begin
        found    = 1'b1;
        best_urg = urgent_i[i];
        best_age = age_i[i];
        best_oh  = N_SRC'(1) << i;
      end
    end
    pick_o = best_oh;
  end

endmodule

// File: rtl/cdb_arbiter_param.sv
// Common-data-bus arbiter: oldest-first (relative to ROB head) selection of up
// to N_CDB results per cycle with a per-source starvation guard.
module cdb_arbiter_param
  import cdb_arbiter_param_pkg::*;
#(
  parameter int N_SRC        = DEF_N_SRC,
  parameter int N_CDB        = DEF_N_CDB,
  parameter int ROB_IDX_W    = DEF_ROB_IDX_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int EX_W         = DEF_EX_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic [ROB_IDX_W-1:0]                rob_head_i,
  input  logic [N_SRC-1:0]                    src_valid_i,
  input  logic [N_SRC-1:0][ROB_IDX_W-1:0]     src_reorder_i,
  input  logic [N_SRC-1:0][DATA_W-1:0]        src_data_i,
  input  logic [N_SRC-1:0][EX_W-1:0]          src_ex_i,
  output logic [N_SRC-1:0]                    src_ack_o,
  output logic [N_CDB-1:0]                    cdb_valid_o,
  output logic [N_CDB-1:0][ROB_IDX_W-1:0]     cdb_reorder_o,
  output logic [N_CDB-1:0][DATA_W-1:0]        cdb_data_o,
  output logic [N_CDB-1:0][EX_W-1:0]          cdb_ex_o
);

  localparam int             CNT_W = starve_cnt_w(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [N_SRC-1:0][ROB_IDX_W-1:0] age;
  logic [N_SRC-1:0]                urgent;
  logic [N_SRC-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_CDB:0][N_SRC-1:0]       taken;
  logic [N_CDB-1:0][N_SRC-1:0]     pick;
  logic [N_SRC-1:0]                grant;

  logic [N_CDB-1:0]                cdb_valid_q, cdb_valid_d;
  logic [N_CDB-1:0][ROB_IDX_W-1:0] cdb_reorder_q, cdb_reorder_d;
  logic [N_CDB-1:0][DATA_W-1:0]    cdb_data_q, cdb_data_d;
  logic [N_CDB-1:0][EX_W-1:0]      cdb_ex_q, cdb_ex_d;

  // Age wraps in ROB_IDX_W bits, so rob_head movement re-ranks immediately.
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign age[i]    = src_reorder_i[i] - rob_head_i;
    assign urgent[i] = (cnt_q[i] == LIMIT);
  end

  assign taken[0] = '0;
  for (genvar s = 0; s < N_CDB; s++) begin : g_slot
    cdb_age_select #(
      .N_SRC (N_SRC),
      .AGE_W (ROB_IDX_W)
    ) u_sel (
      .req_i    (src_valid_i & ~taken[s]),
      .age_i    (age),
      .urgent_i (urgent),
      .pick_o   (pick[s])
    );
    assign taken[s+1] = taken[s] | pick[s];
  end

  assign grant     = (flush_i || rst_i) ? '0 : taken[N_CDB];
  assign src_ack_o = grant;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (flush_i || !src_valid_i[i] || grant[i]) cnt_d[i] = '0;
      else if (cnt_q[i] != LIMIT)                 cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_comb begin
    cdb_reorder_d = '0;
    cdb_data_d    = '0;
    cdb_ex_d      = '0;
    for (int s = 0; s < N_CDB; s++) begin
      cdb_valid_d[s] = (|pick[s]) && !flush_i;
      for (int i = 0; i < N_SRC; i++) begin
        if (pick[s][i]) begin
          cdb_reorder_d[s] = cdb_reorder_d[s] | src_reorder_i[i];
          cdb_data_d[s]    = cdb_data_d[s]    | src_data_i[i];
          cdb_ex_d[s]      = cdb_ex_d[s]      | src_ex_i[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q         <= '0;
      cdb_valid_q   <= '0;
      cdb_reorder_q <= '0;
      cdb_data_q    <= '0;
      cdb_ex_q      <= '0;
    end else begin
      cnt_q         <= cnt_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_reorder_q <= cdb_reorder_d;
      cdb_data_q    <= cdb_data_d;
      cdb_ex_q      <= cdb_ex_d;
    end
  end

  assign cdb_valid_o   = cdb_valid_q;
  assign cdb_reorder_o = cdb_reorder_q;
  assign cdb_data_o    = cdb_data_q;
  assign cdb_ex_o      = cdb_ex_q;

  // A pending, unacked result must hold its payload until granted.
  for (genvar i = 0; i < N_SRC; i++) begin : g_chk
    a_payload_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      (src_valid_i[i] && !src_ack_o[i] && !flush_i) |=>
      (!src_valid_i[i] || ($stable(src_reorder_i[i]) && $stable(src_data_i[i]) &&
                           $stable(src_ex_i[i]))));
  end

endmodule

// File: tb/tb_cdb_arbiter_param.sv
// Bench for cdb_arbiter_param: two configurations (2 slots/limit 7 and
// 1 slot/limit 3) checked against a sort-based reference model.
module tb_cdb_arbiter_param;
  import cdb_arbiter_param_pkg::*;

  localparam int NS = 8, RW = 4, DW = 32, EW = 8;

  logic clk = 1'b0;
  logic rst, flush;
  logic [RW-1:0] head;
  logic [NS-1:0]         v  [2];
  logic [NS-1:0][RW-1:0] ro [2];
  logic [NS-1:0][DW-1:0] da [2];
  logic [NS-1:0][EW-1:0] ex [2];

  logic [NS-1:0] ack0, ack1;
  logic [1:0]         cv0;
  logic [1:0][RW-1:0] cro0;
  logic [1:0][DW-1:0] cda0;
  logic [1:0][EW-1:0] cex0;
  logic [0:0]         cv1;
  logic [0:0][RW-1:0] cro1;
  logic [0:0][DW-1:0] cda1;
  logic [0:0][EW-1:0] cex1;

  always #5 clk = ~clk;

  cdb_arbiter_param #(.N_SRC(NS), .N_CDB(2), .ROB_IDX_W(RW), .DATA_W(DW), .EX_W(EW),
                      .STARVE_LIMIT(7)) u0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .rob_head_i(head),
    .src_valid_i(v[0]), .src_reorder_i(ro[0]), .src_data_i(da[0]), .src_ex_i(ex[0]),
    .src_ack_o(ack0), .cdb_valid_o(cv0), .cdb_reorder_o(cro0), .cdb_data_o(cda0),
    .cdb_ex_o(cex0));

  cdb_arbiter_param #(.N_SRC(NS), .N_CDB(1), .ROB_IDX_W(RW), .DATA_W(DW), .EX_W(EW),
                      .STARVE_LIMIT(3)) u1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .rob_head_i(head),
    .src_valid_i(v[1]), .src_reorder_i(ro[1]), .src_data_i(da[1]), .src_ex_i(ex[1]),
    .src_ack_o(ack1), .cdb_valid_o(cv1), .cdb_reorder_o(cro1), .cdb_data_o(cda1),
    .cdb_ex_o(cex1));

  int errors = 0, checks = 0;
  int cnt [2][NS];
  logic [NS-1:0] last_ack [2];
  logic [NS-1:0] exp_ack  [2];
  logic [1:0]    exp_cv   [2];
  cdb_src_req_t  exp_pl   [2][2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int nc_of(input int d);  return (d == 0) ? 2 : 1; endfunction
  function automatic int lim_of(input int d); return (d == 0) ? 7 : 3; endfunction

  // Rank every pending source by (urgency, age, index) and grant the first nc.
  task automatic predict(input int d);
    int q[$];
    int a, idx;
    q = {};
    for (int i = 0; i < NS; i++) begin
      if (v[d][i]) begin
        a = (int'(ro[d][i]) - int'(head)) & 15;
        q.push_back(((cnt[d][i] == lim_of(d)) ? 0 : 1024) + a * 16 + i);
      end
    end
    q.sort();
    exp_ack[d] = '0;
    exp_cv[d]  = '0;
    for (int s = 0; s < nc_of(d) && s < q.size(); s++) begin
      idx = q[s] % 16;
      exp_ack[d][idx] = 1'b1;
      exp_cv[d][s]    = 1'b1;
      exp_pl[d][s]    = '{reorder: ro[d][idx], data: da[d][idx], ex: ex[d][idx]};
    end
    if (flush) begin
      exp_ack[d] = '0;
      exp_cv[d]  = '0;
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
    predict(0);
    predict(1);
    last_ack[0] = ack0;
    last_ack[1] = ack1;
    check("ack0", ack0, exp_ack[0]);
    check("ack1", ack1, exp_ack[1]);
    @(posedge clk); #1;
    check("cdb0_valid", cv0, exp_cv[0]);
    check("cdb1_valid", cv1, exp_cv[1][0]);
    for (int s = 0; s < 2; s++)
      if (exp_cv[0][s]) check("cdb0_payload", {cro0[s], cda0[s], cex0[s]}, exp_pl[0][s]);
    if (exp_cv[1][0]) check("cdb1_payload", {cro1[0], cda1[0], cex1[0]}, exp_pl[1][0]);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NS; i++)
        if (flush || !v[d][i] || exp_ack[d][i]) cnt[d][i] = 0;
        else if (cnt[d][i] < lim_of(d))         cnt[d][i]++;
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NS; i++) cnt[d][i] = 0;
  endtask

  // Pulse reset between clock edges; outputs must drop without waiting for an edge.
  task automatic rst_pulse();
    #1 rst = 1'b1;
    #1;
    check("rst_cdb0_valid", cv0, 0);
    check("rst_cdb1_valid", cv1, 0);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic present(input int d, input int i, input int r);
    v[d][i]  = 1'b1;
    ro[d][i] = RW'(r);
    da[d][i] = $urandom;
    ex[d][i] = EW'($urandom);
  endtask

  task automatic refresh();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NS; i++)
        if (!v[d][i] || last_ack[d][i]) begin
          if ($urandom_range(0, 9) < 6) present(d, i, int'($urandom_range(0, 15)));
          else v[d][i] = 1'b0;
        end
    if ($urandom_range(0, 2) == 0) head = RW'($urandom);
    flush = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; head = '0;
    for (int d = 0; d < 2; d++) begin
      v[d] = '0; ro[d] = '0; da[d] = '0; ex[d] = '0; last_ack[d] = '0;
    end
    clear_model();
    for (int i = 0; i < NS; i++) begin present(0, i, i); present(1, i, i); end
    #12;
    check("reset_ack0", ack0, 0);
    check("reset_ack1", ack1, 0);
    check("reset_cdb0_valid", cv0, 0);
    check("reset_cdb0_payload", {cro0, cda0, cex0}, 0);
    check("reset_cdb1_valid", cv1, 0);
    #1 rst = 1'b0;
    v[0] = '0; v[1] = '0;

    // oldest-first with two slots, leftover source next cycle
    present(0, 3, 9); present(0, 5, 2); present(0, 6, 4);
    step();
    check("t1_ack", last_ack[0], 8'h60);
    check("t1_slot0", cro0[0], 2);
    check("t1_slot1", cro0[1], 4);
    v[0][5] = 1'b0; v[0][6] = 1'b0;
    step();
    check("t1_ack_src3", last_ack[0], 8'h08);
    check("t1_slot0_src3", cro0[0], 9);
    v[0] = '0;

    // ROB index wrap-around
    head = 4'd14;
    for (int d = 0; d < 2; d++) begin present(d, 0, 1); present(d, 1, 15); end
    step();
    check("t2_ack_2slot", last_ack[0], 8'h03);
    check("t2_slot0", cro0[0], 15);
    check("t2_slot1", cro0[1], 1);
    check("t2_ack_1slot", last_ack[1], 8'h02);
    v[0] = '0; v[1][1] = 1'b0;
    step();
    check("t2_ack_next", last_ack[1], 8'h01);
    v[1] = '0; head = '0;

    // starvation: youngest source becomes urgent on its 4th waiting cycle
    present(1, 0, 0); present(1, 7, 10);
    for (int k = 1; k <= 4; k++) begin
      step();
      check(k < 4 ? "t3_wait" : "t3_urgent", last_ack[1], k < 4 ? 8'h01 : 8'h80);
      if (last_ack[1][0]) present(1, 0, int'($urandom_range(0, 2)));
    end
    v[1] = '0;

    // equal age: lower index takes slot 0
    present(0, 2, 5); present(0, 4, 5);
    da[0][2] = 32'hA2; da[0][4] = 32'hA4;
    step();
    check("t4_ack", last_ack[0], 8'h14);
    check("t4_slot0", cda0[0], 32'hA2);
    check("t4_slot1", cda0[1], 32'hA4);
    v[0] = '0;

    // flush: no ack, no broadcast, counters cleared
    present(1, 0, 0); present(1, 7, 10);
    for (int k = 0; k < 2; k++) begin
      step();
      if (last_ack[1][0]) present(1, 0, 0);
    end
    for (int i = 0; i < 4; i++) present(0, i, i + 3);
    flush = 1'b1;
    step();
    check("t5_ack0", last_ack[0], 0);
    check("t5_ack1", last_ack[1], 0);
    check("t5_cdb0_valid", cv0, 0);
    check("t5_cdb1_valid", cv1, 0);
    flush = 1'b0;
    step();
    check("t5_cnt_cleared", last_ack[1], 8'h01);
    v[0] = '0; v[1] = '0;

    // async reset in the middle of a broadcast
    present(0, 1, 3); present(1, 1, 3);
    step();
    check("t6_pre_valid", cv0, 2'b01);
    rst_pulse();
    v[0] = '0; v[1] = '0;
    step();

    repeat (400) begin
      refresh();
      step();
      if ($urandom_range(0, 49) == 0) rst_pulse();
    end
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter_param.md
# cdb_arbiter_param

Parametrised common-data-bus arbiter for the out-of-order core: collects completed results from N_SRC functional-unit ports (ALU, branch, LSU, multiplier, CP0 result holders), grants up to N_CDB of them per cycle, and broadcasts the winners on a registered CDB. It adds two things over a fixed-priority arbiter: oldest-first selection relative to the ROB head, and a per-source starvation guard. It sits between the reservation-station result holders and the ROB/CDB snoopers.

## Interface
- N_SRC, 8, number of result sources
- N_CDB, 2, CDB broadcast slots per cycle (1..N_SRC)
- ROB_IDX_W, 4, ROB index width; the ROB holds 2^ROB_IDX_W entries
- DATA_W, 32, result width
- EX_W, 8, packed exception field width
- STARVE_LIMIT, 7, cycles a request may wait before it becomes urgent (≥1)
- clk  in  1  clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  pipeline flush
- rob_head  in  ROB_IDX_W  index of the oldest in-flight ROB entry
- src_valid  in  N_SRC  result pending
- src_reorder  in  N_SRC×ROB_IDX_W  destination ROB index
- src_data  in  N_SRC×DATA_W  result value
- src_ex  in  N_SRC×EX_W  exception info
- src_ack  out  N_SRC  grant; combinational, same cycle as selection
- cdb_valid  out  N_CDB  slot carries a result
- cdb_reorder  out  N_CDB×ROB_IDX_W  ROB index broadcast
- cdb_data  out  N_CDB×DATA_W  value broadcast
- cdb_ex  out  N_CDB×EX_W  exception broadcast

## Operation
- Age of a request = (src_reorder − rob_head) mod 2^ROB_IDX_W, computed in ROB_IDX_W bits with wrap-around. A smaller age is older.
- Each source has a starve counter, ceil(log2(STARVE_LIMIT+1)) bits:
  - When src_valid && !src_ack, it increments and saturates at STARVE_LIMIT.
  - When src_ack, !src_valid, or flush, it clears to 0.
  - A source whose counter equals STARVE_LIMIT is urgent.
- Selection proceeds slot by slot, slot 0 first. Each slot picks among the not-yet-granted valid sources:
  - Urgent sources win over non-urgent ones.
  - Within the same urgency, the oldest wins.
  - On an equal age, the lower source index wins.
- Granted = min(popcount(src_valid), N_CDB). Unused slots get cdb_valid=0 in the next cycle.
- Source contract:
  - Keep src_valid and its payload stable until acked.
  - Drop src_valid, or present a new result, in the cycle after the ack.
  - A payload change while valid and unacked is illegal; this is an assertion.
- flush=1:
  - All src_ack are forced to 0.
  - All starve counters clear.
  - cdb_valid registers load 0 on the next edge.
  - The ROB/CDB state already broadcast is not retracted.
- Reset: cdb_valid, cdb_reorder, cdb_data, cdb_ex and all starve counters are 0. src_ack is 0 while rst is asserted.

## Timing
- A request seen in cycle t is acked in t. Its broadcast appears on cdb_* in t+1 and holds for exactly one cycle unless it is re-granted.
- No combinational path from src_* to cdb_*. The only combinational path is src_* and rob_head → src_ack.
- Worst-case wait for any source, no flush: STARVE_LIMIT + ceil(N_SRC/N_CDB) cycles.
- rob_head changing while a request waits re-ranks that request in the same cycle. There is no state to update.
- When rst deasserts, the first grant may occur in the first cycle after deassertion.
- flush and src_valid in the same cycle: no ack. Sources re-present, or their owners clear them via their own flush.

## Structure
- Shared definitions go in cpu_defs.svh: typedef cdb_src_req_t {reorder, data, ex}, and the cdb_packet_t generalised to N_CDB slots.
- Sub-module cdb_age_select: combinational. Inputs are a request mask, ages and urgent flags; output is a one-hot pick. It is instantiated N_CDB times, and each instance masks out the earlier picks.
- Starve counters and CDB output registers live in the top module.

## Test plan
- rob_head=0; sources 3,5,6 valid with reorder 9,2,4; N_CDB=2.
  - Required: ack 5 and 6 in the same cycle; next cycle cdb slot0=2 and slot1=4; source 3 acked one cycle later.
- Wrap-around: rob_head=14; reorder 1 (age 3) and 15 (age 1).
  - Required: 15 is granted first; with N_CDB=1, 1 is granted the next cycle.
- Starvation: N_CDB=1, STARVE_LIMIT=3; source 7 has age 10; sources 0–6 keep fresh age-0..2 requests.
  - Required: source 7 is acked on the 4th waiting cycle despite being youngest.
- Tie: sources 2 and 4 have equal reorder.
  - Required: source 2 gets slot 0 and source 4 gets slot 1.
- flush asserted with 4 requests pending.
  - Required: no ack that cycle; cdb_valid=0 the next cycle; counters read 0.
- Async reset mid-broadcast (rst pulse between edges).
  - Required: cdb_valid drops to 0 immediately, not at the next edge; src_ack=0 throughout.
